// File: rtl/soc_design_timer_irq_master.sv
// Avalon-MM initiator servicing an interval-timer slave: enables its irq, clears each timeout, counts ticks.
// Optional macro TIMER_IRQ_MASTER_STATUS_READBACK_EN adds a status read before each clear (drives run_status).
module soc_design_timer_irq_master #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned STATUS_ADDR  = 0,
    parameter int unsigned CONTROL_ADDR = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [2:0]        address,
    output logic              chipselect,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    input  logic              irq,
    output logic              tick,
    output logic [CNT_W-1:0]  tick_count,
    output logic              busy,
    output logic              run_status
);

    typedef enum logic [2:0] {
        IDLE,
        EN_WR,
        WAIT_IRQ,
`ifdef TIMER_IRQ_MASTER_STATUS_READBACK_EN
        RD_STS,
        RD_WAIT,
`endif
        CLR_WR,
        SETTLE,
        DIS_WR
    } state_t;

    state_t            state, state_nxt;
    logic              cs_nxt;
    logic              wn_nxt;
    logic [2:0]        addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              tick_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (enable) state_nxt = EN_WR;
            EN_WR:    state_nxt = WAIT_IRQ;
            WAIT_IRQ: begin
                if (!enable) begin
                    state_nxt = DIS_WR;
                end else if (irq) begin
`ifdef TIMER_IRQ_MASTER_STATUS_READBACK_EN
                    state_nxt = RD_STS;
`else
                    state_nxt = CLR_WR;
`endif
                end
            end
`ifdef TIMER_IRQ_MASTER_STATUS_READBACK_EN
            RD_STS:   state_nxt = RD_WAIT;
            RD_WAIT:  state_nxt = CLR_WR;
`endif
            CLR_WR:   state_nxt = SETTLE;
            SETTLE:   state_nxt = WAIT_IRQ;
            DIS_WR:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they are registered yet aligned with the state they belong to.
    always_comb begin
        cs_nxt    = 1'b0;
        wn_nxt    = 1'b1;
        addr_nxt  = '0;
        wdata_nxt = '0;
        tick_nxt  = 1'b0;
        case (state_nxt)
            EN_WR: begin
                cs_nxt    = 1'b1;
                wn_nxt    = 1'b0;
                addr_nxt  = 3'(CONTROL_ADDR);
                wdata_nxt = DATA_W'(1);
            end
`ifdef TIMER_IRQ_MASTER_STATUS_READBACK_EN
            RD_STS: begin
                cs_nxt   = 1'b1;
                addr_nxt = 3'(STATUS_ADDR);
            end
`endif
            CLR_WR: begin
                cs_nxt   = 1'b1;
                wn_nxt   = 1'b0;
                addr_nxt = 3'(STATUS_ADDR);
                tick_nxt = 1'b1;
            end
            DIS_WR: begin
                cs_nxt   = 1'b1;
                wn_nxt   = 1'b0;
                addr_nxt = 3'(CONTROL_ADDR);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            address    <= '0;
            writedata  <= '0;
            tick       <= 1'b0;
            tick_count <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            chipselect <= cs_nxt;
            write_n    <= wn_nxt;
            address    <= addr_nxt;
            writedata  <= wdata_nxt;
            tick       <= tick_nxt;
            busy       <= (state_nxt != IDLE);
            if (tick_nxt) tick_count <= tick_count + 1'b1;
        end
    end

`ifdef TIMER_IRQ_MASTER_STATUS_READBACK_EN
    // readdata is the slave's registered response to the read issued in RD_STS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_status <= 1'b0;
        end else if (state == RD_WAIT) begin
            run_status <= readdata[1];
        end
    end
`else
    logic unused_readdata;
    assign unused_readdata = ^readdata;
    assign run_status      = 1'b0;
`endif

endmodule

// File: tb/tb_soc_design_timer_irq_master.sv
// Bench for soc_design_timer_irq_master: timer slave model, cycle schedule reference model, directed scenarios.
module tb_soc_design_timer_irq_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata = '0;
    logic        irq;
    logic        tick;
    logic [31:0] tick_count;
    logic        busy;
    logic        run_status;

    soc_design_timer_irq_master #(
        .DATA_W(16), .CNT_W(32), .STATUS_ADDR(0), .CONTROL_ADDR(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq), .tick(tick), .tick_count(tick_count),
        .busy(busy), .run_status(run_status)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Interval-timer slave: status = {run, timeout}, control bit0 = irq enable.
    logic sts_to = 1'b0, sts_run = 1'b0, ctl_ie = 1'b0;
    logic timer_on = 1'b0, tmo_req = 1'b0;
    int   tmr_cnt = 0, n_tmo = 0;
    assign irq = sts_to & ctl_ie;

    always @(posedge clk) begin
        if (timer_on) begin
            if (tmr_cnt == 9) begin
                tmr_cnt <= 0;
                sts_to  <= 1'b1;
                n_tmo   <= n_tmo + 1;
            end else tmr_cnt <= tmr_cnt + 1;
        end else tmr_cnt <= 0;
        if (tmo_req) begin
            sts_to <= 1'b1;
            n_tmo  <= n_tmo + 1;
        end
        if (chipselect && !write_n) begin
            if (address == 3'd0) sts_to <= 1'b0;
            if (address == 3'd1) ctl_ie <= writedata[0];
        end
        if (chipselect && write_n && address == 3'd0) readdata <= {14'd0, sts_run, sts_to};
    end

    // Reference model: one entry per bus cycle. kind 0 = idle, 1 = listening for irq, 2 = scripted bus cycle.
    typedef struct packed {
        logic [1:0]  kind;
        logic        cs, wn, tk, cap;
        logic [2:0]  a;
        logic [15:0] d;
    } cyc_t;

    function automatic cyc_t mk(input logic [1:0] k, input logic cs, input logic wn, input logic tk,
                                input logic cap, input logic [2:0] a, input logic [15:0] d);
        cyc_t c;
        c.kind = k; c.cs = cs; c.wn = wn; c.tk = tk; c.cap = cap; c.a = a; c.d = d;
        return c;
    endfunction

    cyc_t        cur;
    cyc_t        sched[$];
    bit          running;
    logic [31:0] exp_cnt;
    logic        exp_run;
    logic        s_en, s_irq, s_rst = 1'b1;
    logic [15:0] s_rd;
    int          pre_seq = 0, pre_seen = 0;
    int          cyc = 0, n_ticks = 0, n_clr = 0, n_wr = 0;
    int          irq_rise_cyc = 0, tick_cyc = 0;
    logic        prev_irq = 1'b0;

    always @(posedge clk) begin
        s_en  <= enable;
        s_irq <= irq;
        s_rd  <= readdata;
        s_rst <= reset;
    end

    task automatic model_reset();
        cur     = mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
        sched.delete();
        running = 1'b0;
        exp_cnt = '0;
        exp_run = 1'b0;
    endtask

    task automatic model_step();
`ifdef TIMER_IRQ_MASTER_STATUS_READBACK_EN
        if (cur.cap) exp_run = s_rd[1];
`endif
        if (sched.size() > 0) begin
            cur = sched.pop_front();
        end else if (cur.kind == 2'd2) begin
            cur = mk(running ? 2'd1 : 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
        end else if (cur.kind == 2'd1) begin
            if (!s_en) begin
                cur     = mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 16'd0);
                running = 1'b0;
            end else if (s_irq) begin
`ifdef TIMER_IRQ_MASTER_STATUS_READBACK_EN
                sched.push_back(mk(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0));
                sched.push_back(mk(2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'd0));
`endif
                sched.push_back(mk(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0));
                sched.push_back(mk(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0));
                cur = sched.pop_front();
            end
        end else if (s_en) begin
            cur     = mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 16'd1);
            running = 1'b1;
        end
        if (cur.tk) exp_cnt = exp_cnt + 32'd1;
    endtask

    always @(negedge clk) begin
        if (reset || s_rst) model_reset();
        else model_step();
        if (pre_seq != pre_seen) begin
            exp_cnt  = '1;
            pre_seen = pre_seq;
        end
        chk("chipselect", {31'd0, chipselect}, {31'd0, cur.cs});
        chk("write_n",    {31'd0, write_n},    {31'd0, cur.wn});
        if (cur.cs) begin
            chk("address",   {29'd0, address},   {29'd0, cur.a});
            chk("writedata", {16'd0, writedata}, {16'd0, cur.d});
        end
        chk("tick",       {31'd0, tick},       {31'd0, cur.tk});
        chk("busy",       {31'd0, busy},       {31'd0, (cur.kind != 2'd0)});
        chk("tick_count", tick_count,          exp_cnt);
        chk("run_status", {31'd0, run_status}, {31'd0, exp_run});
        cyc++;
        if (irq && !prev_irq) irq_rise_cyc = cyc;
        prev_irq = irq;
        if (tick) begin
            n_ticks++;
            tick_cyc = cyc;
        end
        if (chipselect && !write_n) n_wr++;
        if (chipselect && !write_n && address == 3'd0 && writedata == 16'd0) n_clr++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_timeout();
        tmo_req = 1'b1;
        step(1);
        tmo_req = 1'b0;
    endtask

    int base_wr, base_tk, base_clr;

    initial begin
        step(3);
        reset = 1'b0;
        step(2);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Enable: exactly one control write of 1, busy from the next cycle
        base_wr = n_wr;
        enable = 1'b1;
        step(1);
        chk("en_cs",    {31'd0, chipselect}, 32'd1);
        chk("en_wn",    {31'd0, write_n},    32'd0);
        chk("en_addr",  {29'd0, address},    32'd1);
        chk("en_wdata", {16'd0, writedata},  32'd1);
        chk("en_busy",  {31'd0, busy},       32'd1);
        step(3);
        chk("en_onewr", n_wr - base_wr, 32'd1);

        // Periodic timer, 5 timeouts
        base_tk = n_ticks; base_clr = n_clr;
        timer_on = 1'b1;
        for (int i = 0; i < 120 && n_tmo < 5; i++) step(1);
        timer_on = 1'b0;
        step(10);
        chk("per_ticks", n_ticks - base_tk,  32'd5);
        chk("per_clrs",  n_clr - base_clr,   32'd5);
        chk("per_count", tick_count,         32'd5);

        // Latency irq rise -> tick, run_status capture
        sts_run = 1'b1;
        pulse_timeout();
        step(8);
`ifdef TIMER_IRQ_MASTER_STATUS_READBACK_EN
        chk("latency",  tick_cyc - irq_rise_cyc, 32'd3);
        chk("run_on",   {31'd0, run_status},     32'd1);
        sts_run = 1'b0;
        pulse_timeout();
        step(8);
        chk("run_off",  {31'd0, run_status},     32'd0);
`else
        chk("latency",  tick_cyc - irq_rise_cyc, 32'd1);
        chk("run_zero", {31'd0, run_status},     32'd0);
        sts_run = 1'b0;
        pulse_timeout();
        step(8);
`endif
        chk("lat_count", tick_count, 32'd7);

        // irq and enable drop in the same WAIT_IRQ cycle: disable wins
        base_tk = n_ticks;
        pulse_timeout();
        enable = 1'b0;
        step(1);
        chk("dis_cs",    {31'd0, chipselect}, 32'd1);
        chk("dis_wn",    {31'd0, write_n},    32'd0);
        chk("dis_addr",  {29'd0, address},    32'd1);
        chk("dis_wdata", {16'd0, writedata},  32'd0);
        step(1);
        chk("dis_busy",  {31'd0, busy},       32'd0);
        chk("dis_notk",  n_ticks - base_tk,   32'd0);

        // Pending timeout is serviced right after re-enable; count held across disable
        enable = 1'b1;
        step(12);
        chk("reen_count", tick_count, 32'd8);

        // Wrap from all-ones
        force dut.tick_count = '1;
        pre_seq++;
        step(1);
        release dut.tick_count;
        step(1);
        chk("pre_ones", tick_count, 32'hFFFF_FFFF);
        pulse_timeout();
        step(8);
        chk("wrap_zero", tick_count, 32'd0);

        // Reset during CLR_WR
        pulse_timeout();
        for (int i = 0; i < 10 && !tick; i++) step(1);
        chk("clr_seen", {31'd0, tick}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mrst_cs",    {31'd0, chipselect}, 32'd0);
        chk("mrst_wn",    {31'd0, write_n},    32'd1);
        chk("mrst_count", tick_count,          32'd0);
        chk("mrst_busy",  {31'd0, busy},       32'd0);
        step(1);
        reset = 1'b0;
        step(12);
        chk("post_rst_count", tick_count, 32'd1);

        enable = 1'b0;
        step(4);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
